// File: rtl/nios_mult_pkg.sv
// Shared op encoding and elaboration-time parameter helpers for nios_mult_pipe.
package nios_mult_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_op_e;

    localparam int LATENCY_MIN = 2;
    localparam int LATENCY_MAX = 4;

    function automatic int slices(input int data_w, input int slice_w);
        return data_w / slice_w;
    endfunction

    function automatic bit latency_ok(input int latency);
        return (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX);
    endfunction

    function automatic bit widths_ok(input int data_w, input int slice_w);
        return (slice_w > 0) && (data_w % slice_w == 0);
    endfunction

endpackage

// File: rtl/nios_mult_slice.sv
// One SLICE_W x SLICE_W unsigned hard-multiplier slice with registered product,
// enable and synchronous clear.
module nios_mult_slice
    import nios_mult_pkg::*;
#(
    parameter int SLICE_W = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 ena,
    input  logic [SLICE_W-1:0]   a,
    input  logic [SLICE_W-1:0]   b,
    output logic [2*SLICE_W-1:0] p
);

    always_ff @(posedge clk) begin
        if (clr)      p <= '0;
        else if (ena) p <= {{SLICE_W{1'b0}}, a} * {{SLICE_W{1'b0}}, b};
    end

endmodule

// File: rtl/nios_mult_pipe.sv
// Stall-able slice-product multiplier with valid/ready on both sides and a travelling tag.
// Define NIOS_MULT_PIPE_HIGH_EN to build MULH/MULHSU/MULHU; otherwise they complete as illegal.
module nios_mult_pipe
    import nios_mult_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal,
    output logic              busy
);

    localparam int N = slices(DATA_W, SLICE_W);
`ifdef NIOS_MULT_PIPE_HIGH_EN
    localparam int FW = 2 * DATA_W;
`else
    localparam int FW = DATA_W;
`endif

    if (!latency_ok(LATENCY) || !widths_ok(DATA_W, SLICE_W)) begin : g_bad_params
        $error("nios_mult_pipe: illegal LATENCY or DATA_W/SLICE_W combination");
    end

    logic adv;
    logic take;
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv && reset_n;
    assign take     = in_valid && in_ready;

    // Control shadow pipeline; index k is the stage holding the op k cycles after accept.
    logic             sv   [1:LATENCY-1];
    mult_op_e         sop  [1:LATENCY-1];
    logic [TAG_W-1:0] stag [1:LATENCY-1];
`ifdef NIOS_MULT_PIPE_HIGH_EN
    logic [DATA_W-1:0] sa [1:LATENCY-1];
    logic [DATA_W-1:0] sb [1:LATENCY-1];
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 1; k < LATENCY; k++) sv[k] <= 1'b0;
        end else if (adv) begin
            sv[1] <= take;
            for (int k = 2; k < LATENCY; k++) sv[k] <= sv[k-1];
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed when their stage valid is set.
    always_ff @(posedge clk) begin
        if (adv) begin
            sop[1]  <= mult_op_e'(in_op);
            stag[1] <= in_tag;
`ifdef NIOS_MULT_PIPE_HIGH_EN
            sa[1]   <= in_src1;
            sb[1]   <= in_src2;
`endif
            for (int k = 2; k < LATENCY; k++) begin
                sop[k]  <= sop[k-1];
                stag[k] <= stag[k-1];
`ifdef NIOS_MULT_PIPE_HIGH_EN
                sa[k]   <= sa[k-1];
                sb[k]   <= sb[k-1];
`endif
            end
        end
    end

    // Stage 1: every slice product p[i][j] = A[i] * B[j].
    logic [2*SLICE_W-1:0] prod [N][N];
`ifdef NIOS_MULT_PIPE_HIGH_EN
    logic hi_ena;
    assign hi_ena = adv && in_valid && (mult_op_e'(in_op) != MUL);
`endif

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (i + j < N) begin : g_lo
                nios_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
                    .clk (clk),
                    .clr (!reset_n),
                    .ena (adv),
                    .a   (in_src1[i*SLICE_W +: SLICE_W]),
                    .b   (in_src2[j*SLICE_W +: SLICE_W]),
                    .p   (prod[i][j])
                );
            end else begin : g_hi
`ifdef NIOS_MULT_PIPE_HIGH_EN
                // Upper products only feed the high half, so MUL leaves them idle.
                nios_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
                    .clk (clk),
                    .clr (!reset_n),
                    .ena (hi_ena),
                    .a   (in_src1[i*SLICE_W +: SLICE_W]),
                    .b   (in_src2[j*SLICE_W +: SLICE_W]),
                    .p   (prod[i][j])
                );
`else
                assign prod[i][j] = '0;
`endif
            end
        end
    end

    // Adder tree: row sums, then the full sum; extra latency registers between the two levels.
    logic [FW-1:0] row   [N];
    logic [FW-1:0] row_s [N];
    logic [FW-1:0] full_c;
    logic [FW-1:0] full_s;

    // NOTE: blocking assignments accumulate a combinational running sum inside one always_comb.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            row[i] = '0;
            for (int j = 0; j < N; j++)
                row[i] = row[i] + (FW'(prod[i][j]) << (j * SLICE_W));
        end
    end

    if (LATENCY >= 3) begin : g_row_reg
        always_ff @(posedge clk) begin
            if (adv) for (int i = 0; i < N; i++) row_s[i] <= row[i];
        end
    end else begin : g_row_comb
        always_comb for (int i = 0; i < N; i++) row_s[i] = row[i];
    end

    always_comb begin
        full_c = '0;
        for (int i = 0; i < N; i++) full_c = full_c + (row_s[i] << (i * SLICE_W));
    end

    if (LATENCY == 4) begin : g_full_reg
        always_ff @(posedge clk) begin
            if (adv) full_s <= full_c;
        end
    end else begin : g_full_comb
        assign full_s = full_c;
    end

    // Signed correction and half select for the op sitting in the last shadow stage.
    mult_op_e          fop;
    logic [DATA_W-1:0] result;
    logic              illegal;
    assign fop = sop[LATENCY-1];

`ifdef NIOS_MULT_PIPE_HIGH_EN
    logic [DATA_W-1:0] fa, fb, corr;
    always_comb begin
        fa   = sa[LATENCY-1];
        fb   = sb[LATENCY-1];
        corr = '0;
        if ((fop == MULH || fop == MULHSU) && fa[DATA_W-1]) corr = corr + fb;
        if (fop == MULH && fb[DATA_W-1])                     corr = corr + fa;
        illegal = 1'b0;
        result  = (fop == MUL) ? full_s[DATA_W-1:0] : full_s[FW-1:DATA_W] - corr;
    end
`else
    always_comb begin
        illegal = (fop != MUL);
        result  = illegal ? '0 : full_s;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (adv) begin
            out_valid   <= sv[LATENCY-1];
            out_result  <= result;
            out_tag     <= stag[LATENCY-1];
            out_illegal <= illegal;
        end
    end

    always_comb begin
        busy = out_valid;
        for (int k = 1; k < LATENCY; k++) busy = busy | sv[k];
    end

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Directed and reference-model bench for nios_mult_pipe (LATENCY=2 directed, LATENCY=4 random).
module tb_nios_mult_pipe;

`ifdef NIOS_MULT_PIPE_HIGH_EN
    localparam bit HIGH = 1'b1;
`else
    localparam bit HIGH = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
    logic [1:0]  in_op;
    logic [31:0] in_src1, in_src2, out_result;
    logic [4:0]  in_tag, out_tag;

    logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_out_illegal, r_busy;
    logic [1:0]  r_in_op;
    logic [31:0] r_in_src1, r_in_src2, r_out_result;
    logic [4:0]  r_in_tag, r_out_tag;

    int total = 0;
    int bad   = 0;

    nios_mult_pipe #(.DATA_W(32), .SLICE_W(16), .LATENCY(2), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_illegal(out_illegal), .busy(busy)
    );

    nios_mult_pipe #(.DATA_W(32), .SLICE_W(16), .LATENCY(4), .TAG_W(5)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_op(r_in_op),
        .in_src1(r_in_src1), .in_src2(r_in_src2), .in_tag(r_in_tag),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_result(r_out_result),
        .out_tag(r_out_tag), .out_illegal(r_out_illegal), .busy(r_busy)
    );

    // Reference: plain 64-bit integer arithmetic, independent of the slice decomposition.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic ill);
        logic [63:0] u;
        longint      sa, sb, s;
        u  = {32'b0, a} * {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        case (op)
            2'd0:    res = u[31:0];
            2'd1:    begin s = sa * sb;                     res = s[63:32]; end
            2'd2:    begin s = sa * longint'({32'b0, b});   res = s[63:32]; end
            default: res = u[63:32];
        endcase
        ill = !HIGH && (op != 2'd0);
        if (ill) res = 32'h0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'd0; in_src1 = '0; in_src2 = '0; in_tag = '0;
        r_in_valid = 1'b0; r_out_ready = 1'b1;
        r_in_op = 2'd0; r_in_src1 = '0; r_in_src2 = '0; r_in_tag = '0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (out_result !== 32'h0)  begin bad++; $display("FAIL reset_out_result got=%h want=0", out_result); end
        total++; if (out_tag !== 5'h0)      begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        total++; if (out_illegal !== 1'b0)  begin bad++; $display("FAIL reset_out_illegal got=%0b want=0", out_illegal); end
        total++; if (in_ready !== 1'b0)     begin bad++; $display("FAIL reset_in_ready_low got=%0b want=0", in_ready); end
        reset_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1)     begin bad++; $display("FAIL reset_in_ready_release got=%0b want=1", in_ready); end
    endtask

    task automatic test_single(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag,
                               input logic [31:0] exp_res, input logic exp_ill);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_accept in_ready=%0b want=1", name, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early out_valid=%0b want=0", name, out_valid); end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_result !== exp_res || out_tag !== tag || out_illegal !== exp_ill) begin
            bad++;
            $display("FAIL %s got v=%0b res=%h tag=%0d ill=%0b want v=1 res=%h tag=%0d ill=%0b",
                     name, out_valid, out_result, out_tag, out_illegal, exp_res, tag, exp_ill);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r [8];
        logic [31:0] a_v [8];
        logic [31:0] held_r;
        logic [4:0]  held_t;
        int sent, got, extra;
        logic [63:0] p;
        for (int k = 0; k < 8; k++) begin
            a_v[k]   = 32'h0001_0000 * (k + 1) + 32'(k + 3);
            p        = {32'b0, a_v[k]} * 64'h0000_0000_0003_0007;
            exp_r[k] = p[31:0];
        end
        sent = 0; got = 0; extra = 0; held_r = '0; held_t = '0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 8) begin
                in_valid = 1'b1; in_op = 2'd0; in_src1 = a_v[sent];
                in_src2 = 32'h0003_0007; in_tag = 5'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_in_ready cyc=%0d got=%0b want=0", cyc, in_ready); end
                if (cyc == 3) begin
                    held_r = out_result; held_t = out_tag;
                end else begin
                    total++;
                    if (out_valid !== 1'b1 || out_result !== held_r || out_tag !== held_t) begin
                        bad++;
                        $display("FAIL b2b_hold cyc=%0d got v=%0b res=%h tag=%0d want v=1 res=%h tag=%0d",
                                 cyc, out_valid, out_result, out_tag, held_r, held_t);
                    end
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (got >= 8 || out_tag !== 5'(got + 1) || out_result !== exp_r[got]) begin
                    bad++;
                    $display("FAIL b2b_result idx=%0d got res=%h tag=%0d want res=%h tag=%0d",
                             got, out_result, out_tag, (got < 8) ? exp_r[got] : 32'h0, got + 1);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (out_valid) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL b2b_duplicate extra=%0d want=0", extra); end
    endtask

    task automatic test_reset_in_flight();
        int seen;
        seen = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_op = 2'd0; in_src1 = 32'd7; in_src2 = 32'd9; in_tag = 5'd21;
        @(negedge clk);
        in_src1 = 32'd11; in_src2 = 32'd13; in_tag = 5'd22;
        @(negedge clk);
        in_valid = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flight_out_valid got=%0b want=0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL flight_busy got=%0b want=0", busy); end
        reset_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flight_ghost_results got=%0d want=0", seen); end
        test_single("after_reset", 2'd0, 32'd6, 32'd7, 5'd23, 32'd42, 1'b0);
    endtask

    task automatic test_random_l4();
        logic [31:0] q_res [$];
        logic        q_ill [$];
        logic [4:0]  q_tag [$];
        logic [31:0] m_res, h_res;
        logic        m_ill, h_ill;
        logic [4:0]  h_tag;
        int issued;
        bit hold;
        issued = 0; hold = 1'b0;
        for (int cyc = 0; cyc < 60000 && (issued < 10000 || q_res.size() > 0); cyc++) begin
            @(negedge clk);
            r_out_ready = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                if (issued < 10000 && $urandom_range(0, 3) != 0) begin
                    r_in_valid = 1'b1; r_in_op = 2'($urandom_range(0, 3));
                    r_in_src1 = pick(); r_in_src2 = pick(); r_in_tag = 5'(issued);
                end else begin
                    r_in_valid = 1'b0;
                end
            end
            #1;
            if (r_out_valid && r_out_ready) begin
                total++;
                if (q_res.size() == 0) begin
                    bad++;
                    $display("FAIL rand_unexpected got res=%h tag=%0d want no output", r_out_result, r_out_tag);
                end else begin
                    h_res = q_res.pop_front(); h_ill = q_ill.pop_front(); h_tag = q_tag.pop_front();
                    if (r_out_result !== h_res || r_out_tag !== h_tag || r_out_illegal !== h_ill) begin
                        bad++;
                        $display("FAIL rand_result got res=%h tag=%0d ill=%0b want res=%h tag=%0d ill=%0b",
                                 r_out_result, r_out_tag, r_out_illegal, h_res, h_tag, h_ill);
                    end
                end
            end
            if (r_in_valid && r_in_ready) begin
                model(r_in_op, r_in_src1, r_in_src2, m_res, m_ill);
                q_res.push_back(m_res); q_ill.push_back(m_ill); q_tag.push_back(r_in_tag);
                issued++;
                hold = 1'b0;
            end else begin
                hold = r_in_valid;
            end
        end
        r_in_valid = 1'b0;
        total++;
        if (issued != 10000 || q_res.size() != 0) begin
            bad++;
            $display("FAIL rand_drain issued=%0d pending=%0d want issued=10000 pending=0", issued, q_res.size());
        end
    endtask

    initial begin
        test_reset();
        test_single("mul_ones",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 1'b0);
        test_single("mulhu_ones",  2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, HIGH ? 32'hFFFF_FFFE : 32'h0, !HIGH);
        test_single("mulh_ones",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, !HIGH);
        test_single("mulh_min",    2'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, HIGH ? 32'h4000_0000 : 32'h0, !HIGH);
        test_single("mulhsu_ones", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, HIGH ? 32'hFFFF_FFFF : 32'h0, !HIGH);
        test_single("mul_shift",   2'd0, 32'h0001_2345, 32'h0001_0000, 5'd6, 32'h2345_0000, 1'b0);
        test_single("mul_cross",   2'd0, 32'h0002_0003, 32'h0004_0005, 5'd7, 32'h0016_000F, 1'b0);
        test_single("mulhu_3x5",   2'd3, 32'd3, 32'd5, 5'd8, 32'h0000_0000, !HIGH);
        test_single("mul_3x5",     2'd0, 32'd3, 32'd5, 5'd9, 32'h0000_000F, 1'b0);
        test_back_to_back();
        test_reset_in_flight();
        test_random_l4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
